ebpc_nz_expander: RTL and testbench

//  Multi-lane successor of the EBPC decoder's zero/nonzero merge stage.
//  - Takes a block length, a ZNZ bitmask stream (1 = nonzero word) and a stream of

---
 rtl/ebpc_nz_expander.sv | 174 +++++++++++++++++
 tb/tb_ebpc_nz_expander.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebpc_nz_expander.sv
// ebpc_nz_expander: rebuilds the word stream of one EBPC block from its
// zero/nonzero mask and the stream of decoded nonzero values. Words are
// packed LANES per output beat with zeros re-inserted. last_o flags the final
// beat of a block. Each block starts on a fresh mask word.
module ebpc_nz_expander #(
  parameter int DATA_W        = 8,
  parameter int MASK_W        = 8,
  parameter int LANES         = 1,
  parameter int LOG_MAX_WORDS = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [LOG_MAX_WORDS-1:0] num_words_i,
  input  logic                     num_words_vld_i,
  output logic                     num_words_rdy_o,
  input  logic [MASK_W-1:0]        znz_i,
  input  logic                     znz_vld_i,
  output logic                     znz_rdy_o,
  input  logic [DATA_W-1:0]        nz_i,
  input  logic                     nz_vld_i,
  output logic                     nz_rdy_o,
  output logic [LANES*DATA_W-1:0]  data_o,
  output logic [LANES-1:0]         keep_o,
  output logic                     last_o,
  output logic                     vld_o,
  input  logic                     rdy_i
);

  localparam int LPW = $clog2(LANES + 1);
  localparam int MCW = $clog2(MASK_W + 1);
  localparam int RW  = LOG_MAX_WORDS + 1;

  typedef enum logic [1:0] {
    IDLE,
    MASK,
    FILL,
    OUT
  } state_e;

  state_e                  state_q, state_d;
  logic [RW-1:0]           rem_q,   rem_d;    // words still to emit in this block
  logic [LPW-1:0]          lp_q,    lp_d;     // next lane to fill in the beat
  logic [MASK_W-1:0]       mbuf_q,  mbuf_d;   // unconsumed mask bits, bit 0 next
  logic [MCW-1:0]          mcnt_q,  mcnt_d;   // number of valid bits in mbuf
  logic [LANES*DATA_W-1:0] data_q,  data_d;
  logic [LANES-1:0]        keep_q,  keep_d;
  logic                    last_q,  last_d;
  logic                    stop_c;            // scan reached a nonzero lane this cycle

  // Next-state logic: handshakes, lane scan and beat bookkeeping.
  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d         = state_q;
    rem_d           = rem_q;
    lp_d            = lp_q;
    mbuf_d          = mbuf_q;
    mcnt_d          = mcnt_q;
    data_d          = data_q;
    keep_d          = keep_q;
    last_d          = last_q;
    stop_c          = 1'b0;
    num_words_rdy_o = 1'b0;
    znz_rdy_o       = 1'b0;
    nz_rdy_o        = 1'b0;
    vld_o           = 1'b0;

    unique case (state_q)
      IDLE: begin
        num_words_rdy_o = 1'b1;
        if (num_words_vld_i) begin
          rem_d   = RW'(num_words_i) + RW'(1);
          lp_d    = '0;
          data_d  = '0;
          keep_d  = '0;
          last_d  = 1'b0;
          state_d = MASK;
        end
      end

      MASK: begin
        znz_rdy_o = 1'b1;
        if (znz_vld_i) begin
          mbuf_d  = znz_i;
          mcnt_d  = MCW'(MASK_W);
          state_d = FILL;
        end
      end

      FILL: begin
        // Lanes are visited in order starting at lp; zero lanes fill freely,
        // the first nonzero lane takes at most one nz value and ends the scan.
        // nz_rdy_o depends only on registered state, never on nz_vld_i.
        for (int l = 0; l < LANES; l++) begin
          if (!stop_c && int'(lp_d) == l && mcnt_d != '0 && rem_d != '0) begin
            if (mbuf_d[0]) begin
              nz_rdy_o = 1'b1;
              stop_c   = 1'b1;
              if (nz_vld_i) data_d[l*DATA_W +: DATA_W] = nz_i;
            end else begin
              data_d[l*DATA_W +: DATA_W] = '0;
            end
            if (!mbuf_d[0] || nz_vld_i) begin
              keep_d[l] = 1'b1;
              lp_d      = lp_d + LPW'(1);
              mbuf_d    = mbuf_d >> 1;
              mcnt_d    = mcnt_d - MCW'(1);
              rem_d     = rem_d - RW'(1);
            end
          end
        end
        if (lp_d == LPW'(LANES) || rem_d == '0) begin
          last_d  = (rem_d == '0);
          state_d = OUT;
        end else if (mcnt_d == '0) begin
          state_d = MASK;
        end
      end

      OUT: begin
        vld_o = 1'b1;
        if (rdy_i) begin
          data_d = '0;
          keep_d = '0;
          last_d = 1'b0;
          lp_d   = '0;
          if (last_q) begin
            // Leftover mask bits belong to no word; the next block restarts
            // on a fresh mask word.
            mbuf_d  = '0;
            mcnt_d  = '0;
            state_d = IDLE;
          end else if (mcnt_q != '0) begin
            state_d = FILL;
          end else begin
            state_d = MASK;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partial beat and mask.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      lp_q    <= '0;
      mbuf_q  <= '0;
      mcnt_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      rem_q   <= rem_d;
      lp_q    <= lp_d;
      mbuf_q  <= mbuf_d;
      mcnt_q  <= mcnt_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign data_o = data_q;
  assign keep_o = keep_q;
  assign last_o = last_q;

endmodule

// File: tb/tb_ebpc_nz_expander.sv
// Bench for ebpc_nz_expander: one instance with LANES=1 (index 0) and one
// with LANES=4 (index 1). Blocks are expanded by a bench-side model into
// expected beats; handshake drivers feed the DUTs and monitors compare.
module tb_ebpc_nz_expander;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [23:0] nw      [2];
  logic        nw_vld  [2];
  logic        nw_rdy  [2];
  logic [7:0]  znz     [2];
  logic        znz_vld [2];
  logic        znz_rdy [2];
  logic [7:0]  nz      [2];
  logic        nz_vld  [2];
  logic        nz_rdy  [2];
  logic        last    [2];
  logic        vld     [2];
  logic        rdy     [2];
  logic [7:0]  dat0;
  logic [31:0] dat1;
  logic [0:0]  keep0;
  logic [3:0]  keep1;

  ebpc_nz_expander #(.DATA_W(8), .MASK_W(8), .LANES(1), .LOG_MAX_WORDS(24)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n),
    .num_words_i(nw[0]), .num_words_vld_i(nw_vld[0]), .num_words_rdy_o(nw_rdy[0]),
    .znz_i(znz[0]), .znz_vld_i(znz_vld[0]), .znz_rdy_o(znz_rdy[0]),
    .nz_i(nz[0]), .nz_vld_i(nz_vld[0]), .nz_rdy_o(nz_rdy[0]),
    .data_o(dat0), .keep_o(keep0), .last_o(last[0]), .vld_o(vld[0]), .rdy_i(rdy[0])
  );

  ebpc_nz_expander #(.DATA_W(8), .MASK_W(8), .LANES(4), .LOG_MAX_WORDS(24)) u_dut_l4 (
    .clk_i(clk), .rst_ni(rst_n),
    .num_words_i(nw[1]), .num_words_vld_i(nw_vld[1]), .num_words_rdy_o(nw_rdy[1]),
    .znz_i(znz[1]), .znz_vld_i(znz_vld[1]), .znz_rdy_o(znz_rdy[1]),
    .nz_i(nz[1]), .nz_vld_i(nz_vld[1]), .nz_rdy_o(nz_rdy[1]),
    .data_o(dat1), .keep_o(keep1), .last_o(last[1]), .vld_o(vld[1]), .rdy_i(rdy[1])
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          stall_en = 1'b0;
  bit          rdy_hold = 1'b0;
  beat_t       exp_q   [2][$];
  logic [23:0] nw_src  [2][$];
  logic [7:0]  znz_src [2][$];
  logic [7:0]  nz_src  [2][$];
  int          nz_pushed [2] = '{0, 0};
  int          nz_xfer   [2] = '{0, 0};
  int          znz_xfer  [2] = '{0, 0};
  beat_t       e0, e1;

  // Model: expand one block into expected beats and queue its input streams.
  task automatic add_block(input int d, input int n, input bit rnd,
                           input logic [7:0] mfix, input int v0, input int vstep);
    int         lanes = (d == 0) ? 1 : 4;
    int         rem   = n + 1;
    int         lane  = 0;
    int         k     = 0;
    int         v     = v0;
    logic [7:0] m     = '0;
    logic [7:0] val;
    beat_t      b     = '0;
    nw_src[d].push_back(24'(n));
    while (rem > 0) begin
      if (k % 8 == 0) begin
        m = rnd ? 8'($urandom) : mfix;
        znz_src[d].push_back(m);
      end
      if (m[k % 8]) begin
        val = rnd ? 8'($urandom) : 8'(v);
        v += vstep;
        nz_src[d].push_back(val);
        nz_pushed[d]++;
        b.data[lane*8 +: 8] = val;
      end
      b.keep[lane] = 1'b1;
      lane++;
      rem--;
      k++;
      if (lane == lanes || rem == 0) begin
        b.last = (rem == 0);
        exp_q[d].push_back(b);
        b    = '0;
        lane = 0;
      end
    end
  endtask

  // Input drivers: abandon the current item when reset is asserted.
  task automatic drv_nw(input int d);
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || nw_src[d].size() == 0) continue;
      if (stall_en) repeat ($urandom_range(0, 3)) @(negedge clk);
      nw[d] = nw_src[d].pop_front();
      nw_vld[d] = 1'b1;
      while (!nw_rdy[d] && rst_n) @(negedge clk);
      if (rst_n) @(posedge clk);
      #1 nw_vld[d] = 1'b0;
    end
  endtask

  task automatic drv_znz(input int d);
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || znz_src[d].size() == 0) continue;
      if (stall_en) repeat ($urandom_range(0, 3)) @(negedge clk);
      znz[d] = znz_src[d].pop_front();
      znz_vld[d] = 1'b1;
      while (!znz_rdy[d] && rst_n) @(negedge clk);
      if (rst_n) begin
        @(posedge clk);
        znz_xfer[d]++;
      end
      #1 znz_vld[d] = 1'b0;
    end
  endtask

  task automatic drv_nz(input int d);
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || nz_src[d].size() == 0) continue;
      if (stall_en) repeat ($urandom_range(0, 3)) @(negedge clk);
      nz[d] = nz_src[d].pop_front();
      nz_vld[d] = 1'b1;
      while (!nz_rdy[d] && rst_n) @(negedge clk);
      if (rst_n) begin
        @(posedge clk);
        nz_xfer[d]++;
      end
      #1 nz_vld[d] = 1'b0;
    end
  endtask

  // Output ready: random back-pressure when stalling, forced low when held.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++)
      rdy[d] = rdy_hold ? 1'b0 : (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Scoreboard, LANES=1 instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vld[0] === 1'b1 && rdy[0] === 1'b1) begin
      n_tests++;
      if (exp_q[0].size() == 0) begin
        n_fail++;
        $display("FAIL out_l1: unexpected beat data=%h keep=%b last=%b", dat0, keep0, last[0]);
      end else begin
        e0 = exp_q[0].pop_front();
        if (dat0 !== e0.data[7:0] || keep0 !== e0.keep[0:0] || last[0] !== e0.last) begin
          n_fail++;
          $display("FAIL out_l1: got data=%h keep=%b last=%b, want data=%h keep=%b last=%b",
                   dat0, keep0, last[0], e0.data[7:0], e0.keep[0:0], e0.last);
        end
      end
    end
  end

  // Scoreboard, LANES=4 instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vld[1] === 1'b1 && rdy[1] === 1'b1) begin
      n_tests++;
      if (exp_q[1].size() == 0) begin
        n_fail++;
        $display("FAIL out_l4: unexpected beat data=%h keep=%b last=%b", dat1, keep1, last[1]);
      end else begin
        e1 = exp_q[1].pop_front();
        if (dat1 !== e1.data || keep1 !== e1.keep || last[1] !== e1.last) begin
          n_fail++;
          $display("FAIL out_l4: got data=%h keep=%b last=%b, want data=%h keep=%b last=%b",
                   dat1, keep1, last[1], e1.data, e1.keep, e1.last);
        end
      end
    end
  end

  function automatic bit all_empty();
    for (int d = 0; d < 2; d++)
      if (exp_q[d].size() != 0 || nw_src[d].size() != 0 ||
          znz_src[d].size() != 0 || nz_src[d].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic flush_all();
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      nw_src[d].delete();
      znz_src[d].delete();
      nz_src[d].delete();
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (c < budget && !all_empty()) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (!all_empty()) begin
      n_fail++;
      $display("FAIL %s: drain timeout, beats left l1=%0d l4=%0d, want 0",
               name, exp_q[0].size(), exp_q[1].size());
      flush_all();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (vld[0] !== 1'b0 || last[0] !== 1'b0 || znz_rdy[0] !== 1'b0 || nz_rdy[0] !== 1'b0 ||
        nw_rdy[0] !== 1'b1 || dat0 !== 8'h0 || keep0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_l1: vld=%b last=%b znz_rdy=%b nz_rdy=%b nw_rdy=%b data=%h keep=%b, want 0 0 0 0 1 0 0",
               vld[0], last[0], znz_rdy[0], nz_rdy[0], nw_rdy[0], dat0, keep0);
    end
    n_tests++;
    if (vld[1] !== 1'b0 || last[1] !== 1'b0 || znz_rdy[1] !== 1'b0 || nz_rdy[1] !== 1'b0 ||
        nw_rdy[1] !== 1'b1 || dat1 !== 32'h0 || keep1 !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_l4: vld=%b last=%b znz_rdy=%b nz_rdy=%b nw_rdy=%b data=%h keep=%b, want 0 0 0 0 1 0 0",
               vld[1], last[1], znz_rdy[1], nz_rdy[1], nw_rdy[1], dat1, keep1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Mask 1010_0101 with nz 11,22,33,44 on both lane counts.
  task automatic test_basic();
    add_block(0, 7, 1'b0, 8'hA5, 11, 11);
    add_block(1, 7, 1'b0, 8'hA5, 11, 11);
    wait_drain("basic", 200);
  endtask

  // Block ends mid-mask: bits 6,7 are dropped and the following block's
  // nz values must not be swallowed by them.
  task automatic test_partial_mask();
    for (int d = 0; d < 2; d++) begin
      add_block(d, 5, 1'b0, 8'b1110_0001, 9, -1);
      add_block(d, 3, 1'b0, 8'h0F, 77, 1);
    end
    wait_drain("partial_mask", 300);
  endtask

  task automatic test_all_zero();
    int z0 [2];
    int n0 [2];
    for (int d = 0; d < 2; d++) begin
      z0[d] = znz_xfer[d];
      n0[d] = nz_xfer[d];
      add_block(d, 15, 1'b0, 8'h00, 0, 0);
    end
    wait_drain("all_zero", 300);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (znz_xfer[d] - z0[d] != 2 || nz_xfer[d] - n0[d] != 0) begin
        n_fail++;
        $display("FAIL all_zero_hs[%0d]: znz=%0d nz=%0d, want znz=2 nz=0",
                 d, znz_xfer[d] - z0[d], nz_xfer[d] - n0[d]);
      end
    end
  endtask

  task automatic test_stall_out();
    int         c = 0;
    logic [31:0] hd;
    logic [3:0]  hk;
    logic        hl;
    rdy_hold = 1'b1;
    add_block(1, 3, 1'b0, 8'h05, 5, 1);
    while (c < 100 && vld[1] !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (vld[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_out_vld: vld=%b after %0d cycles, want 1", vld[1], c);
    end
    hd = dat1;
    hk = keep1;
    hl = last[1];
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_tests++;
      if (vld[1] !== 1'b1 || dat1 !== hd || keep1 !== hk || last[1] !== hl ||
          znz_rdy[1] !== 1'b0 || nz_rdy[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_out_hold: cyc %0d vld=%b data=%h keep=%b last=%b znz_rdy=%b nz_rdy=%b, want 1 %h %b %b 0 0",
                 i, vld[1], dat1, keep1, last[1], znz_rdy[1], nz_rdy[1], hd, hk, hl);
      end
    end
    rdy_hold = 1'b0;
    wait_drain("stall_out", 100);
  endtask

  task automatic test_reset_mid();
    int c = 0;
    add_block(1, 15, 1'b0, 8'hFF, 1, 1);
    while (c < 100 && !(nz_vld[1] === 1'b1 && nz_rdy[1] === 1'b1)) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (!(nz_vld[1] === 1'b1 && nz_rdy[1] === 1'b1)) begin
      n_fail++;
      $display("FAIL reset_mid_fill: nz handshake not offered in %0d cycles", c);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (vld[1] !== 1'b0 || last[1] !== 1'b0 || znz_rdy[1] !== 1'b0 || nz_rdy[1] !== 1'b0 ||
        nw_rdy[1] !== 1'b1 || dat1 !== 32'h0 || keep1 !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid_out: vld=%b last=%b znz_rdy=%b nz_rdy=%b nw_rdy=%b data=%h keep=%b, want 0 0 0 0 1 0 0",
               vld[1], last[1], znz_rdy[1], nz_rdy[1], nw_rdy[1], dat1, keep1);
    end
    flush_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    add_block(1, 7, 1'b0, 8'hA5, 11, 11);
    add_block(1, 2, 1'b0, 8'h07, 100, 1);
    wait_drain("reset_mid_next", 200);
  endtask

  task automatic test_random();
    int n0 [2];
    for (int d = 0; d < 2; d++) n0[d] = nz_xfer[d] - nz_pushed[d];
    stall_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      add_block(0, $urandom_range(0, 11), 1'b1, 8'h00, 0, 0);
      add_block(1, $urandom_range(0, 23), 1'b1, 8'h00, 0, 0);
    end
    wait_drain("random", 75000);
    stall_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (nz_xfer[d] - nz_pushed[d] != n0[d]) begin
        n_fail++;
        $display("FAIL random_nz_count[%0d]: consumed-pushed=%0d, want %0d",
                 d, nz_xfer[d] - nz_pushed[d], n0[d]);
      end
    end
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      nw[d] = '0;   nw_vld[d]  = 1'b0;
      znz[d] = '0;  znz_vld[d] = 1'b0;
      nz[d] = '0;   nz_vld[d]  = 1'b0;
    end
    fork
      drv_nw(0);
      drv_nw(1);
      drv_znz(0);
      drv_znz(1);
      drv_nz(0);
      drv_nz(1);
    join_none
    test_reset();
    test_basic();
    test_partial_mask();
    test_all_zero();
    test_stall_out();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
